// File: rtl/instr_encoder_loader.sv
// Encodes symbolic operation requests into 32-bit instruction words and writes them
// sequentially into instruction memory. Define INSTR_LOADER_NOP_PAD_EN to NOP-pad the rest of memory on finish.
module instr_encoder_loader #(
    parameter int AW        = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          finish,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs,
    input  logic [4:0]    req_rt,
    input  logic [4:0]    req_shamt,
    input  logic [15:0]   req_imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          full,
    output logic          err,
    output logic [AW:0]   word_count
);

`ifdef INSTR_LOADER_NOP_PAD_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FULL, S_ERR, S_PAD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FULL, S_ERR} state_t;
`endif

    localparam logic [AW-1:0] LP_BASE  = AW'(BASE_ADDR);
    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   r_imem_addr;
    logic [31:0]     r_imem_wdata;
    logic            r_imem_we;
    logic            r_err;
    logic [AW:0]     r_word_count;
    logic            w_accept;
    logic [AW:0]     w_count_inc;

    // Shift ops drop rs; arithmetic/logic ops drop shamt.
    function automatic logic [31:0] f_encode(input logic [2:0]  op,
                                             input logic [4:0]  rd,
                                             input logic [4:0]  rs,
                                             input logic [4:0]  rt,
                                             input logic [4:0]  shamt,
                                             input logic [15:0] imm);
        logic [31:0] w;
        case (op)
            3'd0:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
            3'd1:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
            3'd2:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
            3'd3:    w = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
            3'd4:    w = {6'b000000, 5'd0, rt, rd, shamt, 6'b000000};
            3'd5:    w = {6'b000000, 5'd0, rt, rd, shamt, 6'b000010};
            3'd6:    w = {6'b111111, 5'd0, rd, imm};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    assign req_ready   = (r_state == S_LOAD) & ~start & ~finish;
    assign w_accept    = req_valid & req_ready;
    assign w_count_inc = r_word_count + 1'b1;

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign busy       = (r_state != S_IDLE);
    assign full       = (r_word_count == LP_DEPTH);
    assign err        = r_err;
    assign word_count = r_word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= LP_BASE;
            r_imem_addr  <= LP_BASE;
            r_imem_wdata <= 32'd0;
            r_imem_we    <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_imem_we <= 1'b0;
            if (start) begin
                r_state      <= S_LOAD;
                r_addr       <= LP_BASE;
                r_word_count <= '0;
                r_err        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_LOAD: begin
                        if (finish) begin
`ifdef INSTR_LOADER_NOP_PAD_EN
                            r_state <= S_PAD;
`else
                            r_state <= S_IDLE;
`endif
                        end else if (w_accept) begin
                            if (req_op == 3'd7) begin
                                r_err   <= 1'b1;
                                r_state <= S_ERR;
                            end else begin
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= r_addr;
                                r_imem_wdata <= f_encode(req_op, req_rd, req_rs, req_rt,
                                                         req_shamt, req_imm);
                                r_addr       <= r_addr + 1'b1;
                                r_word_count <= w_count_inc;
                                if (w_count_inc == LP_DEPTH) r_state <= S_FULL;
                            end
                        end
                    end
                    S_FULL, S_ERR: begin
                        if (finish) r_state <= S_IDLE;
                    end
`ifdef INSTR_LOADER_NOP_PAD_EN
                    // One NOP (all-zero SLL) per cycle until memory is filled.
                    S_PAD: begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_addr;
                        r_imem_wdata <= 32'd0;
                        r_addr       <= r_addr + 1'b1;
                        r_word_count <= w_count_inc;
                        if (w_count_inc == LP_DEPTH) r_state <= S_IDLE;
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
